pool2_maxpool: RTL and testbench

- Second max-pooling stage of the CNN datapath; sits directly downstream of the second convolution stage.
- Consumes the 32 ReLU'd 14×14 feature maps and produces 32 maps of 7×7 for the flatten/dense stage.
- 2×2 window, stride 2, no padding.
- Uses the same start/done block handshake as the convolution stages.
- Internal 2-stage comparator pipeline issues one window per cycle.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/max4_pipe.sv | 43 ++++
 rtl/pool2_maxpool.sv | 147 ++++++++++++++
 tb/tb_pool2_maxpool.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants, data type and block FSM states
package cnn_pkg;

    localparam int DATA_W    = 32;
    localparam int CONV2_CH  = 32;
    localparam int CONV2_DIM = 14;
    localparam int POOL2_DIM = 7;

    typedef logic signed [DATA_W-1:0] data_t;

    // Block handshake states shared by the conv and pool stages
    typedef enum logic [2:0] {
        BLK_IDLE,
        BLK_RUN,
        BLK_DRAIN,
        BLK_DONE,
        BLK_WAIT_START_LOW
    } blk_state_e;

endpackage

// File: rtl/max4_pipe.sv
// rtl/max4_pipe.sv - signed 4-input max: row maxima registered, final max combinational
module max4_pipe #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IDX_W  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic signed [DATA_W-1:0] e00_i,
    input  logic signed [DATA_W-1:0] e01_i,
    input  logic signed [DATA_W-1:0] e10_i,
    input  logic signed [DATA_W-1:0] e11_i,
    output logic                     valid_o,
    output logic [IDX_W-1:0]         idx_o,
    output logic signed [DATA_W-1:0] max_o
);

    logic signed [DATA_W-1:0] top_q;
    logic signed [DATA_W-1:0] bot_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    always_ff @(posedge clk) begin
        top_q <= (e01_i > e00_i) ? e01_i : e00_i;
        bot_q <= (e11_i > e10_i) ? e11_i : e10_i;
        idx_q <= idx_i;
    end

    // Second stage is the caller's write register, fed by this compare
    assign max_o   = (bot_q > top_q) ? bot_q : top_q;
    assign valid_o = valid_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/pool2_maxpool.sv
// rtl/pool2_maxpool.sv - 2x2/stride-2 max pooling of the conv2 maps with start/done handshake
module pool2_maxpool #(
    parameter int CHANNELS = cnn_pkg::CONV2_CH,
    parameter int IN_DIM   = cnn_pkg::CONV2_DIM,
    parameter int DATA_W   = cnn_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] in_maps  [CHANNELS][IN_DIM][IN_DIM],
    output logic                     done,
    output logic                     busy,
    output logic signed [DATA_W-1:0] out_maps [CHANNELS][IN_DIM/2][IN_DIM/2]
);

    import cnn_pkg::*;

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int IDX_W   = CW + 2 * DW;
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(OUT_DIM - 1);

    blk_state_e    state_q;
    logic [CW-1:0] c_q;
    logic [DW-1:0] r_q;
    logic [DW-1:0] k_q;
    logic          drain_q;
    logic          done_q;
    logic          busy_q;

    logic [DW:0]   row0;
    logic [DW:0]   row1;
    logic [DW:0]   col0;
    logic [DW:0]   col1;

    logic                     s1_valid;
    logic [IDX_W-1:0]         s1_idx;
    logic signed [DATA_W-1:0] s1_max;
    logic [CW-1:0]            wr_c;
    logic [DW-1:0]            wr_r;
    logic [DW-1:0]            wr_k;

    logic signed [DATA_W-1:0] out_maps_q [CHANNELS][OUT_DIM][OUT_DIM];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLK_IDLE;
            c_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                BLK_IDLE: begin
                    if (start) begin
                        state_q <= BLK_RUN;
                        c_q     <= '0;
                        r_q     <= '0;
                        k_q     <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                BLK_RUN: begin
                    if (k_q != D_LAST) begin
                        k_q <= k_q + 1'b1;
                    end else begin
                        k_q <= '0;
                        if (r_q != D_LAST) begin
                            r_q <= r_q + 1'b1;
                        end else begin
                            r_q <= '0;
                            if (c_q != C_LAST) begin
                                c_q <= c_q + 1'b1;
                            end else begin
                                c_q     <= '0;
                                drain_q <= 1'b0;
                                state_q <= BLK_DRAIN;
                            end
                        end
                    end
                end
                // Two cycles let the last window clear both pipeline stages
                BLK_DRAIN: begin
                    if (drain_q) begin
                        state_q <= BLK_DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                BLK_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= BLK_WAIT_START_LOW;
                end
                BLK_WAIT_START_LOW: begin
                    if (!start) begin
                        state_q <= BLK_IDLE;
                    end
                end
                default: state_q <= BLK_IDLE;
            endcase
        end
    end

    assign row0 = {r_q, 1'b0};
    assign row1 = {r_q, 1'b1};
    assign col0 = {k_q, 1'b0};
    assign col1 = {k_q, 1'b1};

    max4_pipe #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_max4 (
        .clk     (clk),
        .reset   (reset),
        .valid_i (state_q == BLK_RUN),
        .idx_i   ({c_q, r_q, k_q}),
        .e00_i   (in_maps[c_q][row0][col0]),
        .e01_i   (in_maps[c_q][row0][col1]),
        .e10_i   (in_maps[c_q][row1][col0]),
        .e11_i   (in_maps[c_q][row1][col1]),
        .valid_o (s1_valid),
        .idx_o   (s1_idx),
        .max_o   (s1_max)
    );

    assign wr_c = s1_idx[IDX_W-1 -: CW];
    assign wr_r = s1_idx[2*DW-1 -: DW];
    assign wr_k = s1_idx[DW-1:0];

    // Result storage is deliberately unreset; reset only kills the valids
    always_ff @(posedge clk) begin
        if (s1_valid) begin
            out_maps_q[wr_c][wr_r][wr_k] <= s1_max;
        end
    end

    assign out_maps = out_maps_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pool2_maxpool.sv
// tb/tb_pool2_maxpool.sv - scoreboard bench for pool2_maxpool
module tb_pool2_maxpool;

    localparam int CH   = 32;
    localparam int ID   = 14;
    localparam int OD   = 7;
    localparam int DWID = 32;
    localparam int LAT  = CH * OD * OD + 3;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic signed [DWID-1:0] in_maps  [CH][ID][ID];
    logic                   done;
    logic                   busy;
    logic signed [DWID-1:0] out_maps [CH][OD][OD];

    int n_checks;
    int n_fail;
    int exp_q[$];

    pool2_maxpool #(
        .CHANNELS (CH),
        .IN_DIM   (ID),
        .DATA_W   (DWID)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_maps  (in_maps),
        .done     (done),
        .busy     (busy),
        .out_maps (out_maps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic fill_ramp();
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < ID; y++)
                for (int x = 0; x < ID; x++)
                    in_maps[c][y][x] = c * 1000 + y * 14 + x;
    endtask

    task automatic fill_random();
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < ID; y++)
                for (int x = 0; x < ID; x++)
                    in_maps[c][y][x] = $urandom;
    endtask

    task automatic push_ramp();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OD; r++)
                for (int k = 0; k < OD; k++)
                    exp_q.push_back(c * 1000 + (2 * r + 1) * 14 + 2 * k + 1);
    endtask

    task automatic push_model();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OD; r++)
                for (int k = 0; k < OD; k++)
                    exp_q.push_back(max4(in_maps[c][2*r][2*k], in_maps[c][2*r][2*k+1],
                                         in_maps[c][2*r+1][2*k], in_maps[c][2*r+1][2*k+1]));
    endtask

    task automatic compare_outputs(input string tag);
        int e;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OD; r++)
                for (int k = 0; k < OD; k++) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("%s_sb_empty", tag), 1, 0);
                        return;
                    end
                    e = exp_q.pop_front();
                    check($sformatf("%s[%0d][%0d][%0d]", tag, c, r, k), out_maps[c][r][k], e);
                end
    endtask

    task automatic run_pass(input string tag, input bit hold);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_busy_run"}, busy, 1);
        n = 0;
        while (!done && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_busy_end"}, busy, 0);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
        compare_outputs(tag);
    endtask

    initial begin
        int busy_seen;
        int done_low;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        fill_ramp();
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Ramp pass: the bottom-right element is always the window max
        push_ramp();
        run_pass("ramp", 1'b0);
        check("ramp_done_idle", done, 1);

        // Signed/tie windows and max-position sweep over the ramp background
        in_maps[0][0][0] = -5;  in_maps[0][0][1] = -3;
        in_maps[0][1][0] = -7;  in_maps[0][1][1] = -3;
        in_maps[0][0][2] = 42;  in_maps[0][0][3] = 42;
        in_maps[0][1][2] = 42;  in_maps[0][1][3] = 42;
        for (int p = 0; p < 4; p++) begin
            for (int dy = 0; dy < 2; dy++)
                for (int dx = 0; dx < 2; dx++)
                    in_maps[1][2*p + 0 + dy][dx] = (dy * 2 + dx == p) ? 32'h7FFFFFFF : -1;
        end
        push_model();
        run_pass("edge", 1'b0);
        check("neg_tie", out_maps[0][0][0], -3);
        check("all_equal", out_maps[0][0][1], 42);
        for (int p = 0; p < 4; p++)
            check($sformatf("maxpos%0d", p), out_maps[1][p][0], 32'h7FFFFFFF);

        // Held start: one pass only, done stays, busy stays low
        fill_random();
        push_model();
        run_pass("held", 1'b1);
        busy_seen = 0;
        done_low  = 0;
        repeat (3000 - LAT - 1) begin
            @(posedge clk);
            #1;
            if (busy) busy_seen++;
            if (!done) done_low++;
        end
        check("held_busy_reassert", busy_seen, 0);
        check("held_done_drop", done_low, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_done_in_idle", done, 1);
        check("held_busy_in_idle", busy, 0);
        fill_random();
        push_model();
        run_pass("rerun", 1'b0);

        // Reset in the middle of RUN aborts; the next pass must be clean
        fill_random();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (500) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        fill_random();
        push_model();
        run_pass("after_rst", 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
